mem_wb_stage: RTL

Parametrised memory-access stage plus MEM/WB pipeline register for the pipelined RISC-V core. It performs byte-, halfword- and word-wide loads and stores with byte enables and load sign/zero extension. It detects misaligned or illegal accesses and registers all writeback-bound signals. Stall and flush inputs connect it to the hazard unit.

---
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: sized loads/stores with byte
// enables, load extension, misalignment/illegal-size fault detection, stall and flush.
module mem_wb_stage #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [2:0]        Funct3M,
    input  logic [REG_AW-1:0] RDM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic              StallW,
    input  logic              FlushW,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_AW-1:0] RDW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic              FaultW
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int NB    = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [XLEN-1:0]  mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_off;
    logic             unused_addr_bits;

    logic             size_byte;
    logic             size_half;
    logic             size_word;
    logic             size_legal;
    logic             misaligned;
    logic             fault;

    logic             store_en;
    logic [NB-1:0]    byte_en;
    logic [XLEN-1:0]  store_data;

    logic [XLEN-1:0]  raw_word;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [XLEN-1:0]  load_data;

    // Upper address bits beyond the array alias back onto it.
    assign word_idx         = ALUResultM[IDX_W+1:2];
    assign byte_off         = ALUResultM[1:0];
    assign unused_addr_bits = ^ALUResultM[XLEN-1:IDX_W+2];

    always_comb begin
        size_byte = 1'b0;
        size_half = 1'b0;
        size_word = 1'b0;
        unique case (Funct3M)
            F3_B, F3_BU: size_byte = 1'b1;
            F3_H, F3_HU: size_half = 1'b1;
            F3_W:        size_word = 1'b1;
            default:     ;
        endcase
    end

    assign size_legal = size_byte | size_half | size_word;
    assign misaligned = (size_half & byte_off[0]) | (size_word & (byte_off != 2'b00));
    assign fault      = (MemReadM | MemWriteM) & (~size_legal | misaligned);

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        byte_en    = '0;
        store_data = '0;
        if (size_byte) begin
            byte_en    = {{(NB-1){1'b0}}, 1'b1} << byte_off;
            store_data = {NB{WriteDataM[7:0]}};
        end else if (size_half) begin
            byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
            store_data = {(NB/2){WriteDataM[15:0]}};
        end else if (size_word) begin
            byte_en    = '1;
            store_data = WriteDataM;
        end
    end

    assign store_en = MemWriteM & ~fault & ~StallW & ~FlushW & ~rst;

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    assign raw_word = mem[word_idx];

    always_comb begin
        byte_lane = raw_word[7:0];
        unique case (byte_off)
            2'd0: byte_lane = raw_word[7:0];
            2'd1: byte_lane = raw_word[15:8];
            2'd2: byte_lane = raw_word[23:16];
            2'd3: byte_lane = raw_word[31:24];
        endcase
    end

    assign half_lane = byte_off[1] ? raw_word[31:16] : raw_word[15:0];

    // Only loads are extended; every other instruction carries the raw word forward.
    always_comb begin
        load_data = raw_word;
        if (MemReadM) begin
            unique case (Funct3M)
                F3_B:    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
                F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_lane};
                F3_H:    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
                F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_lane};
                default: load_data = raw_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushW) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            FaultW     <= 1'b0;
            RDW        <= '0;
            PCPlus4W   <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
        end else if (!StallW) begin
            RegWriteW  <= RegWriteM & ~fault;
            ResultSrcW <= ResultSrcM;
            FaultW     <= fault;
            RDW        <= RDM;
            PCPlus4W   <= PCPlus4M;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
        end
    end

endmodule
